// File: rtl/nibble_packer.sv
// Packs consecutive 4-bit nibbles (low nibble first) into bytes and queues them
// in a small FIFO toward a valid/ready byte sink; flush emits a pending half-byte.
module nibble_packer #(
    parameter int NIB_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clockfa,
    input  logic                     rstn,
    input  logic [NIB_W-1:0]         byteIn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [2*NIB_W-1:0]       byteout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_partial,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         pack_cnt
);

    localparam int WORD_W = 2 * NIB_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    typedef enum logic {S_LOW, S_HIGH} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NIB_W-1:0]    r_hold;
    logic [WORD_W:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [LVL_W-1:0]    r_level;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_full;
    logic                w_accept;
    logic                w_hold_ld;
    logic                w_push;
    logic                w_pop;
    logic [WORD_W:0]     w_push_word;
    logic [WORD_W:0]     w_head;

    // Ready depends only on registered state so the sink's out_ready never
    // reaches in_ready combinationally.
    assign w_full   = (r_level == LVL_W'(DEPTH));
    assign in_ready = (r_state == S_LOW) | ~w_full;
    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clockfa or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_ld   = 1'b0;
        w_push      = 1'b0;
        w_push_word = '0;
        case (r_state)
            S_LOW: begin
                if (w_accept) begin
                    w_hold_ld   = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                // A completing nibble wins over a coincident flush.
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_push_word = {1'b0, byteIn, r_hold};
                    w_state_nxt = S_LOW;
                end else if (flush && !w_full) begin
                    w_push      = 1'b1;
                    w_push_word = {1'b1, {NIB_W{1'b0}}, r_hold};
                    w_state_nxt = S_LOW;
                end
            end
            default: w_state_nxt = S_LOW;
        endcase
    end

    always_ff @(posedge clockfa or negedge rstn) begin
        if (!rstn) begin
            r_hold <= '0;
        end else if (w_hold_ld) begin
            r_hold <= byteIn;
        end
    end

    always_ff @(posedge clockfa or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_push_word;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clockfa or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head      = r_mem[r_rptr];
    assign out_valid   = (r_level != '0);
    assign byteout     = out_valid ? w_head[WORD_W-1:0] : '0;
    assign out_partial = out_valid & w_head[WORD_W];
    assign level       = r_level;
    assign pack_cnt    = r_cnt;

endmodule
